// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer: owns the 3x3 board, takes human moves,
// paces the CPU move generator, and scores each move for win/draw.
module ttt_game_ctrl #(
  parameter int CPU_DELAY           = 8,
  parameter bit HUMAN_FIRST_DEFAULT = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_human_first,
  input  logic        i_move_valid,
  input  logic [3:0]  i_move_coord,
  input  logic [3:0]  i_cpu_coord,
  output logic [17:0] o_board,
  output logic        o_cpu_req,
  output logic        o_turn,
  output logic [1:0]  o_game_state,
  output logic [1:0]  o_result,
  output logic [3:0]  o_win_line,
  output logic        o_illegal_move,
  output logic        o_cpu_fault,
  output logic [3:0]  o_move_count
);

  typedef enum logic [2:0] {S_IDLE, S_HUMAN, S_CPU, S_CHECK, S_DONE} state_t;

  localparam logic [1:0]  C_EMPTY     = 2'b10;
  localparam logic [1:0]  C_HUMAN     = 2'b01;
  localparam logic [1:0]  C_CPU       = 2'b00;
  localparam logic [17:0] BOARD_EMPTY = 18'h2AAAA;
  localparam logic [7:0]  DELAY       = 8'(CPU_DELAY);
  // Cell triples per line, {c2,c1,c0}; index = line number (lowest wins ties).
  localparam logic [7:0][11:0] LINES = {
    12'h642, 12'h840, 12'h852, 12'h741, 12'h630, 12'h876, 12'h543, 12'h210};

  state_t      r_state, w_state_n;
  logic [17:0] r_board, w_board_n;
  logic [7:0]  r_cnt, w_cnt_n;
  logic        r_turn, w_turn_n;
  logic [1:0]  r_result, w_result_n;
  logic [3:0]  r_win_line, w_win_line_n;
  logic        r_illegal, w_illegal_n;
  logic        r_fault, w_fault_n;
  logic [3:0]  r_move_count, w_move_count_n;
  logic        r_last_mover, w_last_mover_n;

  logic [1:0]  w_mark;
  logic        w_win_any;
  logic [3:0]  w_win_idx;
  logic [3:0]  w_free;
  logic        w_h_ok, w_c_ok;
  logic [3:0]  w_c_idx;

  // Out-of-range indices read as 2'b11 so they never look empty.
  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] c;
    c = 2'b11;
    for (int i = 0; i < 9; i++)
      if (idx == 4'(i)) c = b[2*i +: 2];
    return c;
  endfunction

  function automatic logic [17:0] put(input logic [17:0] b, input logic [3:0] idx,
                                      input logic [1:0] v);
    logic [17:0] r;
    r = b;
    for (int i = 0; i < 9; i++)
      if (idx == 4'(i)) r[2*i +: 2] = v;
    return r;
  endfunction

  // Line scan for the last mover's mark, plus lowest empty cell for CPU fallback.
  always_comb begin
    w_mark    = r_last_mover ? C_HUMAN : C_CPU;
    w_win_any = 1'b0;
    w_win_idx = 4'hF;
    for (int l = 7; l >= 0; l--) begin
      if (cell_of(r_board, LINES[l][3:0])  == w_mark &&
          cell_of(r_board, LINES[l][7:4])  == w_mark &&
          cell_of(r_board, LINES[l][11:8]) == w_mark) begin
        w_win_any = 1'b1;
        w_win_idx = 4'(l);
      end
    end
    w_free = 4'd0;
    for (int i = 8; i >= 0; i--)
      if (r_board[2*i +: 2] == C_EMPTY) w_free = 4'(i);
    w_h_ok  = (i_move_coord <= 4'd8) && (cell_of(r_board, i_move_coord) == C_EMPTY);
    w_c_ok  = (i_cpu_coord  <= 4'd8) && (cell_of(r_board, i_cpu_coord)  == C_EMPTY);
    w_c_idx = w_c_ok ? i_cpu_coord : w_free;
  end

  // Next-state and next-register values; start overrides everything.
  always_comb begin
    w_state_n      = r_state;
    w_board_n      = r_board;
    w_cnt_n        = r_cnt;
    w_turn_n       = r_turn;
    w_result_n     = r_result;
    w_win_line_n   = r_win_line;
    w_illegal_n    = 1'b0;
    w_fault_n      = 1'b0;
    w_move_count_n = r_move_count;
    w_last_mover_n = r_last_mover;
    if (i_start) begin
      w_board_n      = BOARD_EMPTY;
      w_move_count_n = 4'd0;
      w_result_n     = 2'd0;
      w_win_line_n   = 4'hF;
      w_turn_n       = i_human_first;
      w_cnt_n        = DELAY;
      w_state_n      = i_human_first ? S_HUMAN : S_CPU;
    end else begin
      case (r_state)
        S_HUMAN: begin
          if (i_move_valid) begin
            if (w_h_ok) begin
              w_board_n      = put(r_board, i_move_coord, C_HUMAN);
              w_move_count_n = r_move_count + 4'd1;
              w_last_mover_n = 1'b1;
              w_state_n      = S_CHECK;
            end else begin
              w_illegal_n = 1'b1;
            end
          end
        end
        S_CPU: begin
          if (r_cnt <= 8'd1) begin
            w_board_n      = put(r_board, w_c_idx, C_CPU);
            w_fault_n      = ~w_c_ok;
            w_move_count_n = r_move_count + 4'd1;
            w_last_mover_n = 1'b0;
            w_state_n      = S_CHECK;
          end else begin
            w_cnt_n = r_cnt - 8'd1;
          end
        end
        S_CHECK: begin
          if (w_win_any) begin
            w_result_n   = r_last_mover ? 2'd1 : 2'd2;
            w_win_line_n = w_win_idx;
            w_state_n    = S_DONE;
          end else if (r_move_count == 4'd9) begin
            w_result_n = 2'd3;
            w_state_n  = S_DONE;
          end else begin
            w_turn_n  = ~r_turn;
            w_cnt_n   = DELAY;
            w_state_n = r_last_mover ? S_CPU : S_HUMAN;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers, async clear.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_board      <= BOARD_EMPTY;
      r_cnt        <= 8'd0;
      r_turn       <= HUMAN_FIRST_DEFAULT;
      r_result     <= 2'd0;
      r_win_line   <= 4'hF;
      r_illegal    <= 1'b0;
      r_fault      <= 1'b0;
      r_move_count <= 4'd0;
      r_last_mover <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_board      <= w_board_n;
      r_cnt        <= w_cnt_n;
      r_turn       <= w_turn_n;
      r_result     <= w_result_n;
      r_win_line   <= w_win_line_n;
      r_illegal    <= w_illegal_n;
      r_fault      <= w_fault_n;
      r_move_count <= w_move_count_n;
      r_last_mover <= w_last_mover_n;
    end
  end

  // Game phase decode; cpu_req follows state so reset drops it immediately.
  always_comb begin
    case (r_state)
      S_HUMAN, S_CPU, S_CHECK: o_game_state = 2'd1;
      S_DONE:                  o_game_state = 2'd2;
      default:                 o_game_state = 2'd0;
    endcase
  end

  assign o_cpu_req      = (r_state == S_CPU);
  assign o_board        = r_board;
  assign o_turn         = r_turn;
  assign o_result       = r_result;
  assign o_win_line     = r_win_line;
  assign o_illegal_move = r_illegal;
  assign o_cpu_fault    = r_fault;
  assign o_move_count   = r_move_count;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: table of game steps plus reset/start corners.
module tb_ttt_game_ctrl;
  localparam int DLY = 8;
  localparam logic [1:0] OP_START = 2'd0, OP_HUM = 2'd1, OP_CPU = 2'd2;

  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0, hf = 1'b0, mv = 1'b0;
  logic [3:0]  mcoord = 4'd0, ccoord = 4'd0;
  logic [17:0] board;
  logic        cpu_req, turn, ill, flt;
  logic [1:0]  gs, res;
  logic [3:0]  wl, mc;

  int n_tests = 0, n_fail = 0;

  ttt_game_ctrl #(.CPU_DELAY(DLY), .HUMAN_FIRST_DEFAULT(1'b1)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_human_first(hf),
    .i_move_valid(mv), .i_move_coord(mcoord), .i_cpu_coord(ccoord),
    .o_board(board), .o_cpu_req(cpu_req), .o_turn(turn), .o_game_state(gs),
    .o_result(res), .o_win_line(wl), .o_illegal_move(ill), .o_cpu_fault(flt),
    .o_move_count(mc));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] arg;
    string      brd;   // cell 0 first: '.' empty, 'H' human, 'C' cpu
    logic [1:0] gs;
    logic       turn;
    logic [3:0] mc;
    logic [1:0] res;
    logic [3:0] wl;
    logic       pulse; // illegal_move (human op) or cpu_fault (cpu op)
    string      name;
  } vec_t;

  vec_t vq[$];

  function automatic logic [17:0] enc(input string s);
    logic [17:0] b;
    byte c;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      c = s[i];
      b[2*i +: 2] = (c == "H") ? 2'b01 : (c == "C") ? 2'b00 : 2'b10;
    end
    return b;
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] arg, input string brd,
                              input logic [1:0] g, input logic t, input logic [3:0] m,
                              input logic [1:0] r, input logic [3:0] w, input logic p,
                              input string nm);
    vec_t v;
    v.op = op; v.arg = arg; v.brd = brd; v.gs = g; v.turn = t; v.mc = m;
    v.res = r; v.wl = w; v.pulse = p; v.name = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input vec_t v);
    chk({v.name, ".board"}, 32'(board), 32'(enc(v.brd)));
    chk({v.name, ".gs"},    32'(gs),    32'(v.gs));
    chk({v.name, ".mc"},    32'(mc),    32'(v.mc));
    chk({v.name, ".res"},   32'(res),   32'(v.res));
    chk({v.name, ".wl"},    32'(wl),    32'(v.wl));
    if (v.gs == 2'd1) chk({v.name, ".turn"}, 32'(turn), 32'(v.turn));
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    case (v.op)
      OP_START: begin
        start = 1'b1; hf = v.arg[0];
        @(negedge clk);
        start = 1'b0;
        chk({v.name, ".ill"}, 32'(ill), 32'd0);
        chk_state(v);
      end
      OP_HUM: begin
        mv = 1'b1; mcoord = v.arg;
        @(negedge clk);
        mv = 1'b0;
        chk({v.name, ".ill"}, 32'(ill), 32'(v.pulse));
        @(negedge clk);
        chk({v.name, ".ill_end"}, 32'(ill), 32'd0);
        chk_state(v);
      end
      default: begin
        ccoord = v.arg;
        n = 0;
        while (cpu_req && n < 300) begin
          n++;
          @(negedge clk);
        end
        chk({v.name, ".req_cycles"}, 32'(n), 32'(DLY));
        chk({v.name, ".flt"}, 32'(flt), 32'(v.pulse));
        chk({v.name, ".brd_w"}, 32'(board), 32'(enc(v.brd)));
        @(negedge clk);
        chk({v.name, ".flt_end"}, 32'(flt), 32'd0);
        chk_state(v);
      end
    endcase
  endtask

  initial begin
    // Game A: occupied/out-of-range rejects, CPU fallback, CPU wins on column 2-5-8
    vq.push_back(mk(OP_START, 1, ".........", 1, 1, 0, 0, 15, 0, "a_start"));
    vq.push_back(mk(OP_HUM,   4, "....H....", 1, 0, 1, 0, 15, 0, "a_h4"));
    vq.push_back(mk(OP_CPU,   0, "C...H....", 1, 1, 2, 0, 15, 0, "a_c0"));
    vq.push_back(mk(OP_HUM,   4, "C...H....", 1, 1, 2, 0, 15, 1, "a_h4_occ1"));
    vq.push_back(mk(OP_HUM,   4, "C...H....", 1, 1, 2, 0, 15, 1, "a_h4_occ2"));
    vq.push_back(mk(OP_HUM,   9, "C...H....", 1, 1, 2, 0, 15, 1, "a_h9"));
    vq.push_back(mk(OP_HUM,   1, "CH..H....", 1, 0, 3, 0, 15, 0, "a_h1"));
    vq.push_back(mk(OP_CPU,   2, "CHC.H....", 1, 1, 4, 0, 15, 0, "a_c2"));
    vq.push_back(mk(OP_HUM,   3, "CHCHH....", 1, 0, 5, 0, 15, 0, "a_h3"));
    vq.push_back(mk(OP_CPU,   4, "CHCHHC...", 1, 1, 6, 0, 15, 1, "a_c4_fallback"));
    vq.push_back(mk(OP_HUM,   6, "CHCHHCH..", 1, 0, 7, 0, 15, 0, "a_h6"));
    vq.push_back(mk(OP_CPU,   8, "CHCHHCH.C", 2, 0, 8, 2, 5,  0, "a_c8_win"));
    vq.push_back(mk(OP_HUM,   7, "CHCHHCH.C", 2, 0, 8, 2, 5,  0, "a_done_ign"));
    // Game B: human wins top row
    vq.push_back(mk(OP_START, 1, ".........", 1, 1, 0, 0, 15, 0, "b_start"));
    vq.push_back(mk(OP_HUM,   0, "H........", 1, 0, 1, 0, 15, 0, "b_h0"));
    vq.push_back(mk(OP_CPU,   3, "H..C.....", 1, 1, 2, 0, 15, 0, "b_c3"));
    vq.push_back(mk(OP_HUM,   1, "HH.C.....", 1, 0, 3, 0, 15, 0, "b_h1"));
    vq.push_back(mk(OP_CPU,   4, "HH.CC....", 1, 1, 4, 0, 15, 0, "b_c4"));
    vq.push_back(mk(OP_HUM,   2, "HHHCC....", 2, 1, 5, 1, 0,  0, "b_h2_win"));
    vq.push_back(mk(OP_HUM,   5, "HHHCC....", 2, 1, 5, 1, 0,  0, "b_done_ign"));
    // Game C: CPU first, full-board draw, one out-of-range CPU coord
    vq.push_back(mk(OP_START, 0, ".........", 1, 0, 0, 0, 15, 0, "c_start"));
    vq.push_back(mk(OP_CPU,   0, "C........", 1, 1, 1, 0, 15, 0, "c_c0"));
    vq.push_back(mk(OP_HUM,   4, "C...H....", 1, 0, 2, 0, 15, 0, "c_h4"));
    vq.push_back(mk(OP_CPU,   2, "C.C.H....", 1, 1, 3, 0, 15, 0, "c_c2"));
    vq.push_back(mk(OP_HUM,   1, "CHC.H....", 1, 0, 4, 0, 15, 0, "c_h1"));
    vq.push_back(mk(OP_CPU,   7, "CHC.H..C.", 1, 1, 5, 0, 15, 0, "c_c7"));
    vq.push_back(mk(OP_HUM,   6, "CHC.H.HC.", 1, 0, 6, 0, 15, 0, "c_h6"));
    vq.push_back(mk(OP_CPU,  15, "CHCCH.HC.", 1, 1, 7, 0, 15, 1, "c_c15_fallback"));
    vq.push_back(mk(OP_HUM,   5, "CHCCHHHC.", 1, 0, 8, 0, 15, 0, "c_h5"));
    vq.push_back(mk(OP_CPU,   8, "CHCCHHHCC", 2, 0, 9, 3, 15, 0, "c_c8_draw"));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.board", 32'(board), 32'h2AAAA);
    chk("rst.gs",    32'(gs),    32'd0);
    chk("rst.req",   32'(cpu_req), 32'd0);
    chk("rst.turn",  32'(turn),  32'd1);
    chk("rst.wl",    32'(wl),    32'hF);
    chk("rst.mc",    32'(mc),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.gs", 32'(gs), 32'd0);

    foreach (vq[i]) run_vec(vq[i]);

    // Reset in the middle of a CPU think phase clears without waiting for a clock
    start = 1'b1; hf = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("d.req_on", 32'(cpu_req), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("d.req_async", 32'(cpu_req), 32'd0);
    chk("d.board",     32'(board),   32'h2AAAA);
    chk("d.gs",        32'(gs),      32'd0);
    chk("d.mc",        32'(mc),      32'd0);
    @(negedge clk);
    chk("d.turn", 32'(turn), 32'd1);
    chk("d.res",  32'(res),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("d.idle", 32'(gs), 32'd0);

    // start with a simultaneous move: the move is dropped silently
    start = 1'b1; hf = 1'b1; mv = 1'b1; mcoord = 4'd4;
    @(negedge clk);
    start = 1'b0; mv = 1'b0;
    chk("e.board", 32'(board), 32'h2AAAA);
    chk("e.gs",    32'(gs),    32'd1);
    chk("e.mc",    32'(mc),    32'd0);
    chk("e.turn",  32'(turn),  32'd1);
    chk("e.ill",   32'(ill),   32'd0);
    @(negedge clk);
    chk("e.ill2",  32'(ill),   32'd0);
    chk("e.board2", 32'(board), 32'h2AAAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
